sisc_core_ctrl: RTL and testbench

- Control and execute core of the SISC multicycle processor: instruction register, control FSM, 32-bit ALU, status register and branch-target unit in one block.
- Sits between the PC/instruction memory (supplies instr, pc_inc) and the register file (supplies rsa/rsb, receives write port).
- Drives PC update controls and the branch target address.

---
 rtl/sisc_pkg.sv | 65 ++++++
 rtl/sisc_alu_unit.sv | 59 +++++
 rtl/sisc_core_ctrl.sv | 146 ++++++++++++++
 tb/tb_sisc_core_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control/execute core.
// Contents: fixed datapath widths, opcode and ALU function codes, the control
// FSM state type, status flag bit positions, and small decode helpers used by
// the core and its ALU.
package sisc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int REG_W  = 4;

    // Opcodes (IR[31:28]); anything not listed here executes as a NOP.
    localparam logic [3:0] OP_ALU_REG = 4'b0001;
    localparam logic [3:0] OP_ALU_IMM = 4'b0010;
    localparam logic [3:0] OP_BRA     = 4'b0100;
    localparam logic [3:0] OP_BRR     = 4'b0101;
    localparam logic [3:0] OP_BNE     = 4'b0110;
    localparam logic [3:0] OP_BNR     = 4'b0111;
    localparam logic [3:0] OP_HLT     = 4'b1111;

    // ALU function codes (IR[27:24] for ALU opcodes).
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b0110;
    localparam logic [3:0] ALU_SHR = 4'b0111;

    // Status register layout is {C,V,N,Z}.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        ST_START0,
        ST_START1,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ALU_REG) || (op == OP_ALU_IMM);
    endfunction

    // BRA/BRR: taken on any selected flag set, or unconditionally when mm is 0.
    // BNE/BNR: taken when none of the selected flags are set.
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic [3:0] mm,
                                          input logic [3:0] stat);
        logic hit;
        hit = |(mm & stat);
        case (op)
            OP_BRA, OP_BRR: return hit || (mm == 4'b0000);
            OP_BNE, OP_BNR: return !hit;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sisc_alu_unit.sv
// Combinational 32-bit ALU with status flag generation.
// Ports:
//   a_i      operand A (register file port A)
//   b_i      operand B (register B or sign-extended immediate)
//   fn_i     function select (ALU_* codes)
//   result_o ALU result
//   flags_o  {C,V,N,Z} for this result; C and V are only meaningful for ADD/SUB
module sisc_alu_unit
    import sisc_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        fn_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    logic              is_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              carry;
    logic              ovf;

    // SUB is A + ~B + 1 so one adder serves both; the carry out then means
    // "no borrow".
    assign is_sub = (fn_i == ALU_SUB);
    assign b_eff  = is_sub ? ~b_i : b_i;
    assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        result_o = a_i;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (fn_i)
            ALU_ADD, ALU_SUB: begin
                result_o = sum[DATA_W-1:0];
                carry    = sum[DATA_W];
                ovf      = (a_i[DATA_W-1] == b_eff[DATA_W-1]) &&
                           (sum[DATA_W-1] != a_i[DATA_W-1]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOT: result_o = ~a_i;
            ALU_SHL: result_o = a_i << b_i[4:0];
            ALU_SHR: result_o = a_i >> b_i[4:0];
            default: result_o = a_i;
        endcase

        flags_o         = '0;
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_V] = ovf;
        flags_o[FLAG_N] = result_o[DATA_W-1];
        flags_o[FLAG_Z] = (result_o == '0);
    end

endmodule

// File: rtl/sisc_core_ctrl.sv
// SISC multicycle processor control and execute core: instruction register,
// control FSM, ALU, status register and branch target unit.
// Ports:
//   CLK, RST_F           clock (rising edge) and async active-low reset
//   instr, pc_inc        instruction at current PC and address of the next one
//   rsa, rsb             register file read data
//   read_rega/read_regb  register file read indices (IR[23:20] / IR[19:16])
//   write_reg, wb_data   register file write index and registered ALU result
//   rf_we                register file write enable (WRITEBACK of ALU ops)
//   pc_write, pc_sel     PC load enable and source (0 = pc_inc, 1 = br_addr)
//   br_addr              branch target (combinational)
//   stat                 status register {C,V,N,Z}
//   halted               high while the core sits in HALT
module sisc_core_ctrl
    import sisc_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_F,
    input  logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] pc_inc,
    input  logic [DATA_W-1:0] rsa,
    input  logic [DATA_W-1:0] rsb,
    output logic [REG_W-1:0]  read_rega,
    output logic [REG_W-1:0]  read_regb,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              rf_we,
    output logic              pc_write,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] br_addr,
    output logic [3:0]        stat,
    output logic              halted
);

    state_t            state_q;
    logic [DATA_W-1:0] ir_q;
    logic [3:0]        stat_q;
    logic [3:0]        flags_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              pc_write_q;
    logic              pc_sel_q;
    logic              rf_we_q;
    logic              halted_q;

    logic [3:0]        op;
    logic [3:0]        mm;
    logic [ADDR_W-1:0] imm;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    assign op  = ir_q[31:28];
    assign mm  = ir_q[27:24];
    assign imm = ir_q[15:0];

    assign read_rega = ir_q[23:20];
    assign read_regb = ir_q[19:16];
    assign write_reg = (op == OP_ALU_IMM) ? ir_q[19:16] : ir_q[15:12];

    // Relative branches add to the address of the following instruction and
    // wrap at 16 bits.
    assign br_addr = ((op == OP_BRR) || (op == OP_BNR)) ? pc_inc + imm : imm;

    assign alu_b = (op == OP_ALU_IMM) ? {{(DATA_W-ADDR_W){imm[ADDR_W-1]}}, imm} : rsb;

    sisc_alu_unit u_alu (
        .a_i      (rsa),
        .b_i      (alu_b),
        .fn_i     (mm),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // Control outputs are registered: each is set on the transition into the
    // state where it must be high. The DECODE branch decision therefore looks
    // ahead at the incoming instruction while still in FETCH; stat is already
    // final at that point because WRITEBACK updated it a cycle earlier.
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q    <= ST_START0;
            ir_q       <= '0;
            stat_q     <= '0;
            flags_q    <= '0;
            wb_data_q  <= '0;
            pc_write_q <= 1'b0;
            pc_sel_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            pc_write_q <= 1'b0;
            pc_sel_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            case (state_q)
                ST_START0: state_q <= ST_START1;
                ST_START1: begin
                    state_q    <= ST_FETCH;
                    pc_write_q <= 1'b1;
                end
                ST_FETCH: begin
                    ir_q    <= instr;
                    state_q <= ST_DECODE;
                    if (branch_taken(instr[31:28], instr[27:24], stat_q)) begin
                        pc_write_q <= 1'b1;
                        pc_sel_q   <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (op == OP_HLT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    wb_data_q <= alu_result;
                    flags_q   <= alu_flags;
                    state_q   <= ST_MEM;
                end
                ST_MEM: begin
                    rf_we_q <= is_alu_op(op);
                    state_q <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    if (is_alu_op(op)) begin
                        stat_q <= flags_q;
                    end
                    state_q    <= ST_FETCH;
                    pc_write_q <= 1'b1;
                end
                ST_HALT:  state_q <= ST_HALT;
                default:  state_q <= ST_START0;
            endcase
        end
    end

    assign wb_data  = wb_data_q;
    assign rf_we    = rf_we_q;
    assign pc_write = pc_write_q;
    assign pc_sel   = pc_sel_q;
    assign stat     = stat_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_sisc_core_ctrl.sv
// Self-checking bench for sisc_core_ctrl. Each instruction's expected
// behaviour is computed by an independent model and queued when the
// instruction is presented in FETCH, then popped and compared as the DUT
// steps through DECODE..WRITEBACK.
module tb_sisc_core_ctrl;

    logic        CLK = 1'b0;
    logic        RST_F;
    logic [31:0] instr;
    logic [15:0] pc_inc;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [3:0]  read_rega;
    logic [3:0]  read_regb;
    logic [3:0]  write_reg;
    logic [31:0] wb_data;
    logic        rf_we;
    logic        pc_write;
    logic        pc_sel;
    logic [15:0] br_addr;
    logic [3:0]  stat;
    logic        halted;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] wb;
        logic [3:0]  wreg;
        logic [3:0]  stat;
        logic        we;
        logic        pw;
        logic        ps;
        logic [15:0] br;
        logic        is_br;
        logic        halt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] stat_m;

    sisc_core_ctrl dut (
        .CLK       (CLK),
        .RST_F     (RST_F),
        .instr     (instr),
        .pc_inc    (pc_inc),
        .rsa       (rsa),
        .rsb       (rsb),
        .read_rega (read_rega),
        .read_regb (read_regb),
        .write_reg (write_reg),
        .wb_data   (wb_data),
        .rf_we     (rf_we),
        .pc_write  (pc_write),
        .pc_sel    (pc_sel),
        .br_addr   (br_addr),
        .stat      (stat),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: expected observable effects of one instruction; also
    // advances the modelled status register for ALU ops.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                   input logic [31:0] b, input logic [15:0] pci);
        exp_t        e;
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [31:0] bb;
        logic [31:0] r;
        logic [32:0] s;
        logic        c;
        logic        v;
        logic        taken;
        op = ins[31:28];
        mm = ins[27:24];
        e.wb = 32'h0; e.wreg = 4'h0; e.we = 1'b0; e.pw = 1'b0; e.ps = 1'b0;
        e.is_br = 1'b0; e.halt = (op == 4'hF);
        e.br = (op == 4'h5 || op == 4'h7) ? pci + ins[15:0] : ins[15:0];
        if (op >= 4'h4 && op <= 4'h7) begin
            e.is_br = 1'b1;
            if (op <= 4'h5) taken = ((mm & stat_m) != 4'h0) || (mm == 4'h0);
            else            taken = ((mm & stat_m) == 4'h0);
            e.pw = taken;
            e.ps = taken;
        end
        if (op == 4'h1 || op == 4'h2) begin
            bb = (op == 4'h2) ? {{16{ins[15]}}, ins[15:0]} : b;
            c = 1'b0;
            v = 1'b0;
            case (mm)
                4'h0: begin
                    s = {1'b0, a} + {1'b0, bb};
                    r = s[31:0];
                    c = s[32];
                    v = (a[31] == bb[31]) && (r[31] != a[31]);
                end
                4'h1: begin
                    r = a - bb;
                    c = (a >= bb);
                    v = (a[31] != bb[31]) && (r[31] != a[31]);
                end
                4'h2:    r = a & bb;
                4'h3:    r = a | bb;
                4'h4:    r = a ^ bb;
                4'h5:    r = ~a;
                4'h6:    r = a << bb[4:0];
                4'h7:    r = a >> bb[4:0];
                default: r = a;
            endcase
            e.wb   = r;
            e.we   = 1'b1;
            e.wreg = (op == 4'h2) ? ins[19:16] : ins[15:12];
            stat_m = {c, v, r[31], (r == 32'h0)};
        end
        e.stat = stat_m;
        return e;
    endfunction

    // Release reset at a falling edge and walk START0/START1 into FETCH.
    task automatic release_reset();
        RST_F = 1'b1;
        checks++;
        if (pc_write !== 1'b0) begin
            errors++;
            $display("FAIL start0_pc_write: got %b expected 0", pc_write);
        end
        @(negedge CLK);
        checks++;
        if (pc_write !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL start1_outputs: pc_write=%b halted=%b expected 0 0", pc_write, halted);
        end
        @(negedge CLK);
        checks++;
        if (pc_write !== 1'b1 || pc_sel !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: pc_write=%b pc_sel=%b expected 1 0", pc_write, pc_sel);
        end
    endtask

    // Present one instruction in FETCH and follow it to the next FETCH
    // (or into HALT).
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] a,
                             input logic [31:0] b, input logic [15:0] pci);
        exp_t       e;
        logic [3:0] stat_before;
        checks++;
        if (pc_write !== 1'b1 || pc_sel !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL fetch_state %h: pc_write=%b pc_sel=%b halted=%b expected 1 0 0",
                     ins, pc_write, pc_sel, halted);
        end
        stat_before = stat_m;
        sb.push_back(model(ins, a, b, pci));
        instr = ins; rsa = a; rsb = b; pc_inc = pci;

        @(negedge CLK);  // DECODE
        e = sb.pop_front();
        checks++;
        if (pc_write !== e.pw || pc_sel !== e.ps || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL decode_ctrl %h: pc_write=%b pc_sel=%b rf_we=%b expected %b %b 0",
                     ins, pc_write, pc_sel, rf_we, e.pw, e.ps);
        end
        if (e.is_br) begin
            checks++;
            if (br_addr !== e.br) begin
                errors++;
                $display("FAIL br_addr %h: got %h expected %h", ins, br_addr, e.br);
            end
        end

        @(negedge CLK);  // EXECUTE or HALT
        if (e.halt) begin
            checks++;
            if (halted !== 1'b1 || pc_write !== 1'b0 || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL halt_entry: halted=%b pc_write=%b rf_we=%b expected 1 0 0",
                         halted, pc_write, rf_we);
            end
            return;
        end
        checks++;
        if (rf_we !== 1'b0 || pc_write !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL execute_ctrl %h: rf_we=%b pc_write=%b halted=%b expected 0 0 0",
                     ins, rf_we, pc_write, halted);
        end

        @(negedge CLK);  // MEM
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL mem_rf_we %h: got %b expected 0", ins, rf_we);
        end

        @(negedge CLK);  // WRITEBACK
        checks++;
        if (rf_we !== e.we || stat !== stat_before) begin
            errors++;
            $display("FAIL wb_ctrl %h: rf_we=%b stat=%b expected %b %b",
                     ins, rf_we, stat, e.we, stat_before);
        end
        if (e.we) begin
            checks++;
            if (wb_data !== e.wb || write_reg !== e.wreg) begin
                errors++;
                $display("FAIL wb_data %h: data=%h reg=%0d expected %h %0d",
                         ins, wb_data, write_reg, e.wb, e.wreg);
            end
        end

        @(negedge CLK);  // next FETCH
        checks++;
        if (stat !== e.stat || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL stat %h: stat=%b rf_we=%b expected %b 0", ins, stat, rf_we, e.stat);
        end
    endtask

    task automatic test_reset();
        RST_F = 1'b0;
        instr = 32'h0; pc_inc = 16'h0; rsa = 32'h0; rsb = 32'h0;
        stat_m = 4'h0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({pc_write, pc_sel, rf_we, halted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {pc_write, pc_sel, rf_we, halted});
        end
        checks++;
        if (stat !== 4'h0 || wb_data !== 32'h0 || br_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: stat=%h wb=%h br=%h expected 0 0 0", stat, wb_data, br_addr);
        end
        checks++;
        if ({read_rega, read_regb, write_reg} !== 12'h000) begin
            errors++;
            $display("FAIL reset_regs: got %h expected 000", {read_rega, read_regb, write_reg});
        end
        release_reset();
    endtask

    task automatic test_alu();
        run_instr(32'h1012_3000, 32'd7, 32'd5, 16'h0001);           // ADD -> 12
        checks++;
        if (read_rega !== 4'h1 || read_regb !== 4'h2) begin
            errors++;
            $display("FAIL read_regs: got %h %h expected 1 2", read_rega, read_regb);
        end
        run_instr(32'h1112_3000, 32'h8000_0000, 32'h1, 16'h0002);   // SUB overflow
        run_instr(32'h2034_FFFF, 32'h10, 32'hDEAD_BEEF, 16'h0003);  // ADDI -1
        run_instr(32'h1034_5000, 32'hFFFF_FFFF, 32'h1, 16'h0004);   // ADD carry -> zero
        for (int f = 2; f <= 9; f++) begin
            run_instr({4'h1, 4'(f), 4'h5, 4'h6, 4'h7, 12'h000},
                      $urandom, $urandom, 16'h0010);
        end
        run_instr(32'h2660_0004, 32'h8000_0001, 32'h0, 16'h0005);   // SHLI by 4
        run_instr(32'h1145_6000, 32'd9, 32'd9, 16'h0006);           // SUB zero: Z=1 C=1
    endtask

    task automatic test_branch();
        // stat is {C,V,N,Z} = 1001 from the preceding SUB.
        run_instr(32'h5100_FFFC, 32'h0, 32'h0, 16'h0010);  // BRR Z: taken, 0x000C
        run_instr(32'h7100_FFFC, 32'h0, 32'h0, 16'h0010);  // BNR Z: not taken
        run_instr(32'h4000_1234, 32'h0, 32'h0, 16'h0020);  // BRA mm=0: taken
        run_instr(32'h4200_4321, 32'h0, 32'h0, 16'h0020);  // BRA N: not taken
        run_instr(32'h6200_0ABC, 32'h0, 32'h0, 16'h0020);  // BNE N: taken
        run_instr(32'h7000_8000, 32'h0, 32'h0, 16'hFFF0);  // BNR mm=0: taken, wraps
    endtask

    task automatic test_nop();
        run_instr(32'h0F12_3456, 32'h1, 32'h2, 16'h0030);
        run_instr(32'h3012_3456, 32'h1, 32'h2, 16'h0031);
        run_instr(32'h8F12_3456, 32'h1, 32'h2, 16'h0032);
        run_instr(32'hE012_3456, 32'h1, 32'h2, 16'h0033);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_instr({4'(1 + (i % 2)), 4'($urandom_range(0, 7)), 8'($urandom),
                       16'($urandom)}, $urandom, $urandom, 16'($urandom));
        end
    endtask

    task automatic test_abort();
        // Reset during MEM of an ADD must suppress its write and clear wb_data.
        instr = 32'h1012_3000; rsa = 32'd100; rsb = 32'd23;
        repeat (3) @(negedge CLK);
        RST_F = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || wb_data !== 32'h0 || stat !== 4'h0) begin
            errors++;
            $display("FAIL abort_reset: rf_we=%b wb=%h stat=%b expected 0 0 0", rf_we, wb_data, stat);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (rf_we !== 1'b0 || pc_write !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold: rf_we=%b pc_write=%b expected 0 0", rf_we, pc_write);
            end
        end
        stat_m = 4'h0;
        release_reset();
        run_instr(32'h1012_3000, 32'd100, 32'd23, 16'h0040);
    endtask

    task automatic test_halt();
        run_instr(32'hF000_0000, 32'h0, 32'h0, 16'h0050);
        instr = 32'h4000_0001;  // would be a taken branch if fetched
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            checks++;
            if (halted !== 1'b1 || pc_write !== 1'b0 || rf_we !== 1'b0 || pc_sel !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold: halted=%b pc_write=%b rf_we=%b pc_sel=%b expected 1 0 0 0",
                         halted, pc_write, rf_we, pc_sel);
            end
        end
        RST_F = 1'b0;
        @(negedge CLK);
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_cleared: got %b expected 0", halted);
        end
        stat_m = 4'h0;
        release_reset();
        run_instr(32'h1012_3000, 32'd1, 32'd2, 16'h0060);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_nop();
        test_back_to_back();
        test_abort();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
